// File: rtl/ram_fifo_ctrl.sv
// Pointer/flag controller that wraps a dual-port synchronous RAM as a FIFO.
// Drives RAM write/read strobes and addresses; carries no data path.
module ram_fifo_ctrl #(
    parameter int addr_size = 8,
    parameter int ram_depth = 256,
    parameter int af_level  = 192
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    output logic                 wr_enb,
    output logic [addr_size-1:0] wr_addr,
    output logic                 rd_enb,
    output logic [addr_size-1:0] rd_addr,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic [addr_size:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int CW = addr_size + 1;
    localparam logic [addr_size:0]   DEPTH_C  = CW'(ram_depth);
    localparam logic [addr_size:0]   AF_C     = CW'(af_level);
    localparam logic [addr_size:0]   CNT_ONE  = CW'(1);
    localparam logic [addr_size-1:0] PTR_ONE  = addr_size'(1);

    logic [addr_size-1:0] wr_ptr_r;
    logic [addr_size-1:0] rd_ptr_r;
    logic [addr_size:0]   count_r;
    logic [addr_size:0]   count_nxt_s;
    logic                 full_r;
    logic                 empty_r;
    logic                 almost_full_r;
    logic                 rd_valid_r;
    logic                 overflow_r;
    logic                 underflow_r;
    logic                 push_ok_s;
    logic                 pop_ok_s;

    // Acceptance from registered flags; reset suppresses RAM strobes immediately.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        if (reset) begin
            push_ok_s = 1'b0;
            pop_ok_s  = 1'b0;
        end else begin
            push_ok_s = push & ~full_r;
            pop_ok_s  = pop & ~empty_r;
        end
    end

    // Next-state occupancy; simultaneous accepted push and pop cancel out.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, occupancy and flag registers; flags track the next count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            full_r        <= 1'b0;
            empty_r       <= 1'b1;
            almost_full_r <= 1'b0;
            rd_valid_r    <= 1'b0;
            overflow_r    <= 1'b0;
            underflow_r   <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r       <= count_nxt_s;
            full_r        <= (count_nxt_s == DEPTH_C);
            empty_r       <= (count_nxt_s == '0);
            almost_full_r <= (count_nxt_s >= AF_C);
            rd_valid_r    <= pop_ok_s;
            overflow_r    <= overflow_r | (push & full_r);
            underflow_r   <= underflow_r | (pop & empty_r);
        end
    end

    assign wr_enb      = push_ok_s;
    assign rd_enb      = pop_ok_s;
    assign wr_addr     = wr_ptr_r;
    assign rd_addr     = rd_ptr_r;
    assign count       = count_r;
    assign full        = full_r;
    assign empty       = empty_r;
    assign almost_full = almost_full_r;
    assign rd_valid    = rd_valid_r;
    assign overflow    = overflow_r;
    assign underflow   = underflow_r;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: a queue-based FIFO reference model plus a simple
// synchronous RAM model, driven by directed and randomized push/pop steps.
module tb_ram_fifo_ctrl;

    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int AF    = 192;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic          pop;
    logic          wr_enb;
    logic [AW-1:0] wr_addr;
    logic          rd_enb;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic [7:0]    din;
    logic [7:0]    dout;
    logic [7:0]    mem [DEPTH];

    int checks = 0;
    int errors = 0;

    bit [7:0] m_q [$];
    int       m_wptr;
    int       m_rptr;
    bit       m_ovf;
    bit       m_unf;
    bit       m_rv;
    bit [7:0] m_rdata;

    ram_fifo_ctrl #(.addr_size(AW), .ram_depth(DEPTH), .af_level(AF)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .wr_enb(wr_enb), .wr_addr(wr_addr), .rd_enb(rd_enb), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .full(full), .empty(empty), .almost_full(almost_full),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Stand-in for the external dual-port RAM with registered read data.
    always @(posedge clk) begin
        if (wr_enb) mem[wr_addr] <= din;
        if (rd_enb) dout <= mem[rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_wptr = 0;
        m_rptr = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_rv   = 1'b0;
    endtask

    task automatic check_all();
        int n;
        n = m_q.size();
        chk("count", 32'(count), n);
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(n >= AF));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("rd_valid", 32'(rd_valid), 32'(m_rv));
        chk("wr_addr", 32'(wr_addr), m_wptr);
        chk("rd_addr", 32'(rd_addr), m_rptr);
        chk("wr_enb", 32'(wr_enb), 32'(push && !reset && n < DEPTH));
        chk("rd_enb", 32'(rd_enb), 32'(pop && !reset && n > 0));
        if (m_rv) chk("data_out", 32'(dout), 32'(m_rdata));
    endtask

    // One clock of stimulus: check at the falling edge, then advance the model.
    task automatic cycle(input bit p, input bit q, input logic [7:0] d);
        bit pa, qa;
        push = p;
        pop  = q;
        din  = d;
        @(negedge clk);
        check_all();
        pa = p && (m_q.size() < DEPTH);
        qa = q && (m_q.size() > 0);
        if (p && !pa) m_ovf = 1'b1;
        if (q && !qa) m_unf = 1'b1;
        m_rv = qa;
        if (qa) begin
            m_rdata = m_q.pop_front();
            m_rptr  = (m_rptr + 1) % DEPTH;
        end
        if (pa) begin
            m_q.push_back(d);
            m_wptr = (m_wptr + 1) % DEPTH;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        push  = 1'b0;
        pop   = 1'b0;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        din   = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        push = 1'b1;
        pop  = 1'b1;
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Async reset mid-cycle discards a pending rd_valid and the count.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'($urandom));
        cycle(1'b0, 1'b1, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        chk("async_count", 32'(count), 32'd0);
        chk("async_empty", 32'(empty), 32'd1);
        chk("async_rd_valid", 32'(rd_valid), 32'd0);
        chk("async_wr_addr", 32'(wr_addr), 32'd0);
        do_reset();

        cycle(1'b1, 1'b0, 8'h11);
        cycle(1'b1, 1'b0, 8'h22);
        cycle(1'b1, 1'b0, 8'h33);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'($urandom));
        cycle(1'b1, 1'b0, 8'hEE);
        cycle(1'b1, 1'b1, 8'hDD);
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        do_reset();
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b1, 8'h5A);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00);

        for (int i = 0; i < 300; i++) cycle(1'b1, 1'b1, 8'($urandom));
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 800; i++) begin
            int bias;
            bias = (i / 200) % 2 == 0 ? 3 : 1;
            cycle(($urandom_range(3, 0) < bias), ($urandom_range(3, 0) >= bias),
                  8'($urandom));
        end
        cycle(1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
